// File: rtl/save_state_chunk.sv
// Save-state chunk endpoint: answers header queries, gathers elements from a local RAM
// for save and scatters elements into it for restore, one transaction per request.
module save_state_chunk #(
  parameter int WIDTH_CODE = 2,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1,
  localparam int DW = 8 << WIDTH_CODE,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          chunk_select,
  input  logic          query_req,
  input  logic [31:0]   chunk_address,
  input  logic          write_req,
  input  logic [63:0]   write_data,
  input  logic          read_req,
  output logic [63:0]   read_data,
  output logic          data_ack,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    state_dbg
);

  // Handshake: in IDLE a request is taken when enable & chunk_select & exactly one of
  // read_req/write_req is high; data_ack then pulses for one cycle, and no new request is
  // taken until the streamer drops its req or deselects this endpoint.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    WAIT    = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [63:0] HEADER = {30'b0, 2'(WIDTH_CODE), 32'(DEPTH)};

  state_t     state, state_nx;
  logic       is_query, is_write, in_range;
  logic [3:0] wait_cnt;
  logic       start, abort, rd_wait, wait_done;
  logic       unused_wdata;

  assign start     = (state == IDLE) && enable && chunk_select && (read_req ^ write_req);
  assign abort     = !(chunk_select && (is_write ? write_req : read_req));
  assign rd_wait   = !is_query && !is_write && in_range;
  assign wait_done = (wait_cnt == 4'(RD_LATENCY - 1));

  assign mem_re    = (state == ACCESS) && rd_wait;
  assign mem_we    = (state == ACCESS) && !is_query && is_write && in_range;
  assign data_ack  = (state == ACK);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Upper element bits beyond DW carry nothing for this width.
  assign unused_wdata = ^(write_data >> DW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCESS;
      ACCESS: begin
        if (abort)        state_nx = IDLE;
        else if (rd_wait) state_nx = WAIT;
        else              state_nx = ACK;
      end
      WAIT: begin
        if (abort)          state_nx = IDLE;
        else if (wait_done) state_nx = ACK;
      end
      ACK:     state_nx = RELEASE;
      RELEASE: if (!chunk_select || !(read_req || write_req)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_query  <= 1'b0;
      is_write  <= 1'b0;
      in_range  <= 1'b0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      read_data <= '0;
    end else begin
      if (start) begin
        is_query <= query_req;
        is_write <= write_req;
        in_range <= (chunk_address < 32'(DEPTH));
        if (!query_req) begin
          mem_addr  <= chunk_address[AW-1:0];
          mem_wdata <= write_data[DW-1:0];
        end
      end
      if (state == ACCESS)    wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
      // Aborted transactions leave read_data untouched; the RAM op itself still completes.
      if (state == ACCESS && !abort) begin
        if (is_query && !is_write)   read_data <= HEADER;
        else if (!is_query && !in_range) read_data <= '0;
      end
      if (state == WAIT && !abort && wait_done) read_data <= 64'(mem_rdata);
    end
  end

endmodule

// File: tb/tb_save_state_chunk.sv
// Bench for save_state_chunk: two endpoints with different geometry, a latency RAM per
// endpoint, directed steps followed by random transactions checked against a shadow model.
module tb_save_state_chunk;

  localparam int DEP_A = 300;
  localparam int DEP_B = 512;

  logic        clk, reset_n, enable, cs_a, cs_b, query_req, write_req, read_req;
  logic [31:0] chunk_address;
  logic [63:0] write_data;

  logic [63:0] read_data_a, read_data_b;
  logic        data_ack_a, data_ack_b, busy_a, busy_b;
  logic [8:0]  mem_addr_a, mem_addr_b;
  logic [31:0] mem_wdata_a, mem_rdata_a;
  logic [15:0] mem_wdata_b, mem_rdata_b;
  logic        mem_we_a, mem_re_a, mem_we_b, mem_re_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  save_state_chunk #(.WIDTH_CODE(2), .DEPTH(DEP_A), .RD_LATENCY(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chunk_select(cs_a),
    .query_req(query_req), .chunk_address(chunk_address), .write_req(write_req),
    .write_data(write_data), .read_req(read_req), .read_data(read_data_a),
    .data_ack(data_ack_a), .busy(busy_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_we(mem_we_a), .mem_re(mem_re_a), .mem_rdata(mem_rdata_a), .state_dbg(state_dbg_a)
  );

  save_state_chunk #(.WIDTH_CODE(1), .DEPTH(DEP_B), .RD_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chunk_select(cs_b),
    .query_req(query_req), .chunk_address(chunk_address), .write_req(write_req),
    .write_data(write_data), .read_req(read_req), .read_data(read_data_b),
    .data_ack(data_ack_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .mem_re(mem_re_b), .mem_rdata(mem_rdata_b), .state_dbg(state_dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAMs with 3-cycle (A) and 1-cycle (B) read latency
  logic [31:0] ram_a [512];
  logic [31:0] pipe_a [3];
  logic [15:0] ram_b [512];
  logic [15:0] pipe_b;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) begin
        ram_a[i] <= '0;
        ram_b[i] <= '0;
      end
      for (int i = 0; i < 3; i++) pipe_a[i] <= '0;
      pipe_b <= '0;
    end else begin
      if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      pipe_a[0] <= ram_a[mem_addr_a];
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_b    <= ram_b[mem_addr_b];
    end
  end
  assign mem_rdata_a = pipe_a[2];
  assign mem_rdata_b = pipe_b;

  // reference model state
  logic [63:0] sh_a [512];
  logic [63:0] sh_b [512];
  logic [63:0] last_a, last_b;
  logic [31:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) begin
      sh_a[i] = '0;
      sh_b[i] = '0;
    end
    last_a = '0;
    last_b = '0;
  endtask

  task automatic idle_inputs();
    cs_a = 0; cs_b = 0; query_req = 0; write_req = 0; read_req = 0;
    chunk_address = '0; write_data = '0;
  endtask

  // One complete transaction: drive, observe up to 24 cycles, release, compare to model.
  task automatic run_txn(input bit ub, input bit q, input bit w, input logic [31:0] addr,
                         input logic [63:0] data, input bit drop_en);
    int dep, lat, exp_ack, ack_at, acks, re_n, we_n, re_at, we_at;
    logic [63:0] mask, hdr, exp_rd, rd_ack, wd_seen;
    logic [8:0]  re_addr, we_addr;
    bit in_rng, want_re, want_we;
    dep  = ub ? DEP_B : DEP_A;
    lat  = ub ? 1 : 3;
    mask = ub ? 64'hFFFF : 64'hFFFF_FFFF;
    hdr  = ub ? (64'd1 << 32) + 64'(DEP_B) : (64'd2 << 32) + 64'(DEP_A);
    in_rng  = (addr < 32'(dep));
    want_re = !q && !w && in_rng;
    want_we = !q && w && in_rng;
    exp_ack = want_re ? 2 + lat : 2;
    if (q && !w)         exp_rd = hdr;
    else if (!q && !in_rng) exp_rd = '0;
    else if (want_re)    exp_rd = ub ? sh_b[addr[8:0]] : sh_a[addr[8:0]];
    else                 exp_rd = ub ? last_b : last_a;

    @(posedge clk); #1;
    cs_a = !ub; cs_b = ub; query_req = q; write_req = w; read_req = !w;
    chunk_address = addr; write_data = data;
    ack_at = -1; acks = 0; re_n = 0; we_n = 0; re_at = -1; we_at = -1;
    rd_ack = '0; wd_seen = '0; re_addr = '0; we_addr = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (drop_en && cyc == 1) enable = 1'b0;
      if (ub ? data_ack_b : data_ack_a) begin
        acks++;
        if (ack_at < 0) begin
          ack_at = cyc;
          rd_ack = ub ? read_data_b : read_data_a;
        end
      end
      if (ub ? mem_re_b : mem_re_a) begin
        re_n++; re_at = cyc; re_addr = ub ? mem_addr_b : mem_addr_a;
      end
      if (ub ? mem_we_b : mem_we_a) begin
        we_n++; we_at = cyc; we_addr = ub ? mem_addr_b : mem_addr_a;
        wd_seen = ub ? 64'(mem_wdata_b) : 64'(mem_wdata_a);
      end
      if (ack_at >= 0 && cyc >= ack_at + 3) break;
    end
    @(posedge clk); #1;
    idle_inputs();
    enable = 1'b1;
    repeat (2) @(negedge clk);

    check("ack_cycle", 64'(ack_at), 64'(exp_ack));
    check("ack_count", 64'(acks), 64'd1);
    check("read_data", rd_ack, exp_rd);
    check("mem_re_count", 64'(re_n), 64'(want_re));
    check("mem_we_count", 64'(we_n), 64'(want_we));
    if (want_re) begin
      check("mem_re_cycle", 64'(re_at), 64'd1);
      check("mem_re_addr", 64'(re_addr), 64'(addr[8:0]));
    end
    if (want_we) begin
      check("mem_we_cycle", 64'(we_at), 64'd1);
      check("mem_we_addr", 64'(we_addr), 64'(addr[8:0]));
      check("mem_wdata", wd_seen, data & mask);
      if (ub) sh_b[addr[8:0]] = data & mask;
      else    sh_a[addr[8:0]] = data & mask;
    end
    check("busy_after_release", 64'(ub ? busy_b : busy_a), 64'd0);
    if (ub) last_b = exp_rd;
    else    last_a = exp_rd;
  endtask

  task automatic check_a_reset_outputs(input string tag);
    check({tag, "_read_data"}, read_data_a, 64'd0);
    check({tag, "_data_ack"}, 64'(data_ack_a), 64'd0);
    check({tag, "_mem_re"}, 64'(mem_re_a), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we_a), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr_a), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata_a), 64'd0);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acks, busy_seen, kind, sel, dep;
    logic [31:0] addr;
    bit ub;

    // reset
    reset_n = 1'b0; enable = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk); #1;
    check_a_reset_outputs("reset");
    reset_n = 1'b1;

    // header queries on both geometries
    run_txn(1, 1, 0, 32'd0, 64'd0, 0);
    run_txn(0, 1, 0, 32'd0, 64'd0, 0);

    // element write then read back (RD_LATENCY 3)
    run_txn(0, 0, 1, 32'd5, 64'h0000_0000_0000_BEEF, 0);
    run_txn(0, 0, 0, 32'd5, 64'd0, 0);
    run_txn(0, 0, 1, 32'd7, 64'h1234_5678_9ABC_DEF0, 0);
    run_txn(0, 0, 0, 32'd7, 64'd0, 0);

    // range boundary
    run_txn(0, 0, 1, 32'(DEP_A - 1), 64'hFFFF_0000_A5A5_5A5A, 0);
    run_txn(0, 0, 0, 32'(DEP_A - 1), 64'd0, 0);
    run_txn(0, 0, 0, 32'(DEP_A), 64'd0, 0);
    run_txn(0, 0, 1, 32'(DEP_A), 64'h1111_2222_3333_4444, 0);
    run_txn(0, 0, 0, 32'hFFFF_FFFF, 64'd0, 0);

    // header write leaves read_data alone; enable drop mid-transaction does not abort
    run_txn(0, 0, 0, 32'd5, 64'd0, 0);
    run_txn(0, 1, 1, 32'd0, 64'hDEAD, 0);
    run_txn(0, 0, 0, 32'd7, 64'd0, 1);

    // 16-bit endpoint, RD_LATENCY 1
    run_txn(1, 0, 1, 32'd3, 64'hCAFE_1234, 0);
    run_txn(1, 0, 0, 32'd3, 64'd0, 0);

    // enable low: header write held 16 cycles never starts
    @(posedge clk); #1;
    enable = 1'b0; cs_a = 1; query_req = 1; write_req = 1;
    acks = 0; busy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (data_ack_a) acks++;
      if (busy_a) busy_seen++;
    end
    check("en0_acks", 64'(acks), 64'd0);
    check("en0_busy", 64'(busy_seen), 64'd0);

    // both reqs high never starts
    @(posedge clk); #1;
    enable = 1'b1; query_req = 0; read_req = 1; write_req = 1; chunk_address = 32'd5;
    acks = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_ack_a) acks++;
      if (busy_a) busy_seen++;
    end
    check("both_req_acks", 64'(acks), 64'd0);
    check("both_req_busy", 64'(busy_seen), 64'd0);
    @(posedge clk); #1;
    idle_inputs();

    // read_req drops in WAIT: no ack, back to IDLE, read_data held
    @(posedge clk); #1;
    cs_a = 1; read_req = 1; chunk_address = 32'd7;
    repeat (3) @(negedge clk);
    read_req = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_ack_a) acks++;
    end
    check("abort_wait_acks", 64'(acks), 64'd0);
    check("abort_wait_busy", 64'(busy_a), 64'd0);
    check("abort_wait_hold", read_data_a, last_a);
    idle_inputs();

    // deselect in ACCESS: no ack, back to IDLE
    @(posedge clk); #1;
    cs_a = 1; read_req = 1; chunk_address = 32'd5;
    repeat (2) @(negedge clk);
    cs_a = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_ack_a) acks++;
    end
    check("abort_access_acks", 64'(acks), 64'd0);
    check("abort_access_busy", 64'(busy_a), 64'd0);
    idle_inputs();
    run_txn(0, 0, 0, 32'd5, 64'd0, 0);

    // reset asserted in WAIT clears outputs immediately
    @(posedge clk); #1;
    cs_a = 1; read_req = 1; chunk_address = 32'd7;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy_a), 64'd1);
    reset_n = 1'b0;
    #1;
    check_a_reset_outputs("wait_reset");
    idle_inputs();
    repeat (2) @(posedge clk); #1;
    model_clear();
    reset_n = 1'b1;

    // random transactions against the shadow model
    for (int t = 0; t < 40; t++) begin
      ub   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      sel  = $urandom_range(0, 9);
      dep  = ub ? DEP_B : DEP_A;
      if (sel < 6)       addr = 32'($urandom_range(0, 15));
      else if (sel == 6) addr = 32'(dep - 1);
      else if (sel == 7) addr = 32'(dep);
      else if (sel == 8) addr = 32'($urandom_range(dep, 600));
      else               addr = $urandom;
      exp_q.push_back(addr);
      run_txn(ub, kind < 2, kind[0], exp_q.pop_front(), {$urandom, $urandom},
              $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
